// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipe: load-use stall, taken-redirect flush, EX operand forwarding.
// The WB occupant is not tracked because the write-first register file already covers that case.
module hazard_ctrl #(
   parameter int         CNT_W  = 16,
   parameter int         RA_W   = 5,
   parameter logic [1:0] WB_MEM = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rf_wen,
   input  logic [1:0]       id_wb_sel,
   input  logic             ex_br_taken,
   input  logic             mem_stall,
   output logic             stall_pc,
   output logic             stall_id,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic             ex_v_r, ex_wen_r, ex_ld_r;
   logic [RA_W-1:0]  ex_rd_r;
   logic             mem_v_r, mem_wen_r;
   logic [RA_W-1:0]  mem_rd_r;
   logic [1:0]       fwd_a_r, fwd_b_r;
   logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
   logic             lu_s, bubble_s;
   logic [1:0]       fwd_a_nxt_s, fwd_b_nxt_s;

   function automatic logic hit(input logic v, input logic wen,
                                input logic [RA_W-1:0] rd, input logic [RA_W-1:0] src);
      return v & wen & (rd != {RA_W{1'b0}}) & (rd == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic use_src, input logic ex_hit, input logic mem_hit);
      logic [1:0] sel;
      if (use_src && ex_hit) begin
         sel = 2'b01;
      end else if (use_src && mem_hit) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Load-use detection, bubble decision and next forwarding selects for the instruction entering EX.
   always_comb begin
      lu_s = id_valid & ex_ld_r &
             ((id_use_rs1 & hit(ex_v_r, ex_wen_r, ex_rd_r, id_rs1)) |
              (id_use_rs2 & hit(ex_v_r, ex_wen_r, ex_rd_r, id_rs2)));
      bubble_s    = ex_br_taken | lu_s | ~id_valid;
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
      if (!bubble_s) begin
         fwd_a_nxt_s = fwd_sel(id_use_rs1, hit(ex_v_r, ex_wen_r, ex_rd_r, id_rs1),
                               hit(mem_v_r, mem_wen_r, mem_rd_r, id_rs1));
         fwd_b_nxt_s = fwd_sel(id_use_rs2, hit(ex_v_r, ex_wen_r, ex_rd_r, id_rs2),
                               hit(mem_v_r, mem_wen_r, mem_rd_r, id_rs2));
      end else begin
         fwd_a_nxt_s = 2'b00;
         fwd_b_nxt_s = 2'b00;
      end
   end

   // Stall/flush priority: memory freeze, then redirect, then load-use; forced idle while in reset.
   always_comb begin
      stall_pc = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      if (!rst_n) begin
         stall_pc = 1'b0;
      end else if (mem_stall) begin
         stall_pc = 1'b1;
         stall_id = 1'b1;
      end else if (ex_br_taken) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (lu_s) begin
         stall_pc = 1'b1;
         stall_id = 1'b1;
      end else begin
         stall_pc = 1'b0;
      end
   end

   // Shadow pipeline, forwarding selects and saturating counters; everything freezes under mem_stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_v_r      <= 1'b0;
         ex_wen_r    <= 1'b0;
         ex_ld_r     <= 1'b0;
         ex_rd_r     <= {RA_W{1'b0}};
         mem_v_r     <= 1'b0;
         mem_wen_r   <= 1'b0;
         mem_rd_r    <= {RA_W{1'b0}};
         fwd_a_r     <= 2'b00;
         fwd_b_r     <= 2'b00;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else if (!mem_stall) begin
         mem_v_r   <= ex_v_r;
         mem_wen_r <= ex_wen_r;
         mem_rd_r  <= ex_rd_r;
         ex_v_r    <= ~bubble_s;
         ex_wen_r  <= id_rf_wen & ~bubble_s;
         ex_ld_r   <= (id_wb_sel == WB_MEM) & ~bubble_s;
         ex_rd_r   <= id_rd;
         fwd_a_r   <= fwd_a_nxt_s;
         fwd_b_r   <= fwd_b_nxt_s;
         if (lu_s && !ex_br_taken && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (ex_br_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign fwd_a     = fwd_a_r;
   assign fwd_b     = fwd_b_r;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (4-bit counters): driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int RA_W  = 5;

   typedef struct packed {
      logic       stall;
      logic       flush;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [3:0] sc;
      logic [3:0] fc;
   } exp_t;

   logic            clk, rst_n;
   logic            id_valid, id_use_rs1, id_use_rs2, id_rf_wen, ex_br_taken, mem_stall;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic [1:0]      id_wb_sel;
   logic            stall_pc, stall_id, flush_id, flush_ex;
   logic [1:0]      fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   exp_t sb_q[$];
   exp_t m_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   s;

   hazard_ctrl #(.CNT_W(CNT_W), .RA_W(RA_W), .WB_MEM(2'b01)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rf_wen(id_rf_wen),
      .id_wb_sel(id_wb_sel), .ex_br_taken(ex_br_taken), .mem_stall(mem_stall),
      .stall_pc(stall_pc), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic st, input logic fl, input logic [1:0] fa,
                               input logic [1:0] fb, input int sc, input int fc);
      exp_t e;
      e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb;
      e.sc = sc[3:0]; e.fc = fc[3:0];
      return e;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue what the DUT must show this cycle.
   task automatic step(input logic rst, input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic br, input logic ms,
                       input exp_t e);
      @(posedge clk);
      #1;
      rst_n = rst; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
      id_use_rs2 = u2; id_rd = rd; id_rf_wen = wen; id_wb_sel = ld ? 2'b01 : 2'b00;
      ex_br_taken = br; mem_stall = ms;
      sb_q.push_back(e);
   endtask

   task automatic idle(input exp_t e);
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
   endtask

   task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic ld,
                        input logic br, input exp_t e);
      step(1'b1, 1'b1, rs1, u1, rs2, u2, rd, 1'b1, ld, br, 1'b0, e);
   endtask

   // Monitor: compare the DUT against the oldest queued expectation at every falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         m_e = sb_q.pop_front();
         check("stall_pc",  {3'b000, stall_pc}, {3'b000, m_e.stall});
         check("stall_id",  {3'b000, stall_id}, {3'b000, m_e.stall});
         check("flush_id",  {3'b000, flush_id}, {3'b000, m_e.flush});
         check("flush_ex",  {3'b000, flush_ex}, {3'b000, m_e.flush});
         check("fwd_a",     {2'b00, fwd_a},     {2'b00, m_e.fa});
         check("fwd_b",     {2'b00, fwd_b},     {2'b00, m_e.fb});
         check("stall_cnt", stall_cnt,          m_e.sc);
         check("flush_cnt", flush_cnt,          m_e.fc);
      end
   end

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0;
      id_use_rs2 = 1'b0; id_rd = 5'd0; id_rf_wen = 1'b0; id_wb_sel = 2'b00;
      ex_br_taken = 1'b0; mem_stall = 1'b0;

      // reset with random inputs
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              mk(0, 0, 2'b00, 2'b00, 0, 0));
      idle(mk(0, 0, 2'b00, 2'b00, 0, 0));

      // back-to-back ALU producer -> 01
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      idle(mk(0, 0, 2'b01, 2'b00, 0, 0));
      // one in between -> 10
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      idle(mk(0, 0, 2'b10, 2'b00, 0, 0));
      // two in between -> 00
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      idle(mk(0, 0, 2'b00, 2'b00, 0, 0));

      // load-use on rs2: one stall cycle, bubble, then forward from MEM/WB
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, mk(1, 0, 2'b00, 2'b00, 0, 0));
      issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 0));
      idle(mk(0, 0, 2'b00, 2'b10, 1, 0));
      // load to x0: no stall, no forward
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 0));
      issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 0));
      idle(mk(0, 0, 2'b00, 2'b00, 1, 0));

      // taken branch and load-use together: flush wins, stall count unchanged
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 0));
      issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, mk(0, 1, 2'b00, 2'b00, 1, 0));
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 1));
      issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 1, 1));

      // mem_stall for 4 cycles with a pending redirect: fwd holds, flush deferred then counted once
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
              mk(1, 0, 2'b01, 2'b00, 1, 1));
      step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
           mk(0, 1, 2'b01, 2'b00, 1, 1));
      idle(mk(0, 0, 2'b00, 2'b00, 1, 2));

      // 19 load-use stalls: stall_cnt saturates at 15
      s = 1;
      for (int k = 0; k < 19; k++) begin
         issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, mk(0, 0, 2'b00, 2'b00, s, 2));
         issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, mk(1, 0, 2'b00, 2'b00, s, 2));
         s = (s < 15) ? s + 1 : 15;
         issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, s, 2));
         idle(mk(0, 0, 2'b00, 2'b10, s, 2));
      end

      // reset during a stalled redirect returns straight to the reset state
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
           mk(0, 0, 2'b00, 2'b00, 0, 0));
      idle(mk(0, 0, 2'b00, 2'b00, 0, 0));

      repeat (2) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
